// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Turns the UART receiver byte stream into image frames in the frame-buffer BRAM.
// After arm, it hunts for the two-byte header SYNC0 SYNC1. It then writes exactly
// PIX_MAX payload bytes to consecutive BRAM addresses starting at 0.
// If the stream stalls for TIMEOUT_TICKS s_tick pulses mid-frame, the frame is
// dropped with frame_err and the block goes back to hunting without re-arming.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   s_tick          16x-baud sample tick (drives the stall timeout)
//   rx_done_tick    strobe: rx_data holds a new byte
//   rx_data         received byte
//   arm / abort     one-cycle capture request / cancel
//   busy            high whenever not idle
//   we/waddr/wdata  BRAM write port (one-cycle we per payload byte)
//   frame_done      pulse with the final write of a frame
//   frame_err       pulse when a frame is dropped by timeout
//   frame_cnt       completed frames, wraps 255->0
module uart_frame_ctrl #(
  parameter int unsigned PIX_MAX       = 76800,
  parameter int unsigned ADDR_W        = 17,
  parameter logic [7:0]  SYNC0         = 8'hAA,
  parameter logic [7:0]  SYNC1         = 8'h55,
  parameter int unsigned TIMEOUT_TICKS = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              rx_done_tick,
  input  logic [7:0]        rx_data,
  input  logic              arm,
  input  logic              abort,
  output logic              busy,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              frame_done,
  output logic              frame_err,
  output logic [7:0]        frame_cnt
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'(TIMEOUT_TICKS);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIX_MAX - 1);

  typedef enum logic [1:0] {IDLE, HUNT0, HUNT1, LOAD} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_q, pix_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pix_q   <= '0;
      gap_q   <= '0;
      busy_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    gap_d   = gap_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;

    // abort beats everything, including a byte arriving in the same cycle
    if (abort) begin
      state_d = IDLE;
      pix_d   = '0;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm) state_d = HUNT0;
        end
        HUNT0: begin
          if (rx_done_tick && rx_data == SYNC0) state_d = HUNT1;
        end
        HUNT1: begin
          if (rx_done_tick) begin
            if (rx_data == SYNC1) begin
              state_d = LOAD;
              pix_d   = '0;
              gap_d   = '0;
            end else if (rx_data != SYNC0) begin
              // a repeated SYNC0 keeps us waiting for SYNC1
              state_d = HUNT0;
            end
          end
        end
        LOAD: begin
          if (rx_done_tick) begin
            // a byte wins over a simultaneous tick, so the gap simply restarts
            we_d    = 1'b1;
            waddr_d = pix_q;
            wdata_d = rx_data;
            gap_d   = '0;
            if (pix_q == LAST_PIX) begin
              done_d  = 1'b1;
              cnt_d   = cnt_q + 8'd1;
              pix_d   = '0;
              state_d = IDLE;
            end else begin
              pix_d = pix_q + ADDR_W'(1);
            end
          end else if (s_tick) begin
            if (gap_q != GAP_LIM) gap_d = gap_q + GAP_W'(1);
            if (gap_d == GAP_LIM) begin
              err_d   = 1'b1;
              state_d = HUNT0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign busy       = busy_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Testbench for uart_frame_ctrl (PIX_MAX=4, TIMEOUT_TICKS=8).
// A behavioural model tracks "armed / header half-seen / in frame / byte index /
// ticks since last byte" and predicts every output for every cycle. Directed
// scenarios add literal expectations on the observed BRAM write log.
module tb_uart_frame_ctrl;

  localparam int PIX = 4;
  localparam int TO  = 8;
  localparam int AW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s_tick = 1'b0;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          arm = 1'b0;
  logic          abort = 1'b0;
  logic          busy, we, frame_done, frame_err;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata, frame_cnt;

  uart_frame_ctrl #(
    .PIX_MAX(PIX), .ADDR_W(AW), .SYNC0(8'hAA), .SYNC1(8'h55), .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx_done_tick(rx_done_tick),
    .rx_data(rx_data), .arm(arm), .abort(abort), .busy(busy), .we(we),
    .waddr(waddr), .wdata(wdata), .frame_done(frame_done), .frame_err(frame_err),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   m_armed = 0, m_seen_sync0 = 0, m_in_frame = 0;
  int   m_idx = 0, m_ticks = 0;
  logic          n_busy = 0, n_we = 0, n_done = 0, n_err = 0;
  logic [7:0]    n_cnt = 0, n_data = 0;
  logic [AW-1:0] n_addr = 0;
  logic          e_busy = 0, e_we = 0, e_done = 0, e_err = 0;
  logic [7:0]    e_cnt = 0, e_data = 0;
  logic [AW-1:0] e_addr = 0;

  task automatic model(input bit r, a, ab, t, v, input logic [7:0] d);
    n_we = 0; n_done = 0; n_err = 0;
    if (r) begin
      m_armed = 0; m_seen_sync0 = 0; m_in_frame = 0; m_idx = 0; m_ticks = 0;
      n_cnt = 0; n_addr = 0; n_data = 0;
    end else if (ab) begin
      m_armed = 0; m_seen_sync0 = 0; m_in_frame = 0;
    end else if (!m_armed) begin
      if (a) begin m_armed = 1; m_seen_sync0 = 0; m_in_frame = 0; end
    end else if (!m_in_frame) begin
      if (v) begin
        if (m_seen_sync0 && d == 8'h55) begin
          m_in_frame = 1; m_idx = 0; m_ticks = 0; m_seen_sync0 = 0;
        end else begin
          m_seen_sync0 = (d == 8'hAA);
        end
      end
    end else begin
      if (v) begin
        n_we = 1; n_addr = AW'(m_idx); n_data = d; m_ticks = 0;
        if (m_idx == PIX - 1) begin
          n_done = 1; n_cnt = 8'((int'(n_cnt) + 1) % 256);
          m_armed = 0; m_in_frame = 0;
        end else m_idx++;
      end else if (t) begin
        m_ticks++;
        if (m_ticks == TO) begin
          n_err = 1; m_in_frame = 0; m_seen_sync0 = 0;
        end
      end
    end
    n_busy = m_armed;
  endtask

  // ---------------- compare process ----------------
  bit chk_en = 0;
  logic [11:0] wlog[$];
  int done_seen = 0, err_seen = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs{busy,we,done,err,cnt,addr,data}",
          32'({busy, we, frame_done, frame_err, frame_cnt, waddr, wdata}),
          32'({e_busy, e_we, e_done, e_err, e_cnt, e_addr, e_data}));
      if (we === 1'b1) wlog.push_back({waddr, wdata});
      if (frame_done === 1'b1) done_seen++;
      if (frame_err === 1'b1) err_seen++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit r, a, ab, t, v, input logic [7:0] d);
    reset = r; arm = a; abort = ab; s_tick = t; rx_done_tick = v; rx_data = d;
    model(r, a, ab, t, v, d);
    @(posedge clk); #1;
    e_busy = n_busy; e_we = n_we; e_done = n_done; e_err = n_err;
    e_cnt = n_cnt; e_addr = n_addr; e_data = n_data;
    chk_en = 1;
    reset = 0; arm = 0; abort = 0; s_tick = 0; rx_done_tick = 0;
    @(negedge clk); #1;
  endtask

  task automatic send(input logic [7:0] b); cyc(0, 0, 0, 0, 1, b); endtask
  task automatic do_arm(); cyc(0, 1, 0, 0, 0, 8'h00); endtask
  task automatic tick(); cyc(0, 0, 0, 1, 0, 8'h00); endtask
  task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 8'h00); endtask
  task automatic do_reset(); cyc(1, 0, 0, 0, 0, 8'h00); cyc(1, 0, 0, 0, 0, 8'h00); endtask

  task automatic chk_log(input string name, input logic [7:0] d0, d1, d2, d3);
    logic [7:0] exp_d[4];
    exp_d = '{d0, d1, d2, d3};
    chk({name, "_nwrites"}, 32'(wlog.size()), 32'd4);
    for (int i = 0; i < 4 && i < wlog.size(); i++)
      chk({name, "_write"}, 32'(wlog[i]), 32'({AW'(i), exp_d[i]}));
  endtask

  initial begin
    int vprob, tprob, sel;
    logic [7:0] b;
    @(negedge clk); #1;
    do_reset();

    // nominal frame
    wlog.delete();
    do_arm();
    chk("busy_after_arm", 32'(busy), 32'd1);
    send(8'hAA); send(8'h55);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    chk_log("nominal", 8'h10, 8'h20, 8'h30, 8'h40);
    chk("nominal_cnt", 32'(frame_cnt), 32'd1);
    chk("nominal_busy", 32'(busy), 32'd0);
    $display("scenario nominal: writes=%0d cnt=%0d", wlog.size(), frame_cnt);

    // header hunting
    wlog.delete();
    do_arm();
    send(8'h00); send(8'hAA); send(8'hAA); send(8'h55);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk_log("hunt", 8'h01, 8'h02, 8'h03, 8'h04);
    wlog.delete();
    send(8'h12); send(8'hAA); send(8'h13); send(8'hAA); send(8'h55);
    send(8'h05); send(8'h06); send(8'h07); send(8'h08);
    chk("unarmed_nwrites", 32'(wlog.size()), 32'd0);
    $display("scenario hunting: cnt=%0d", frame_cnt);

    // timeout resync
    err_seen = 0;
    do_arm(); send(8'hAA); send(8'h55); send(8'h01); send(8'h02);
    for (int i = 0; i < TO; i++) tick();
    chk("timeout_err_count", 32'(err_seen), 32'd1);
    chk("timeout_cnt", 32'(frame_cnt), 32'd2);
    chk("timeout_busy", 32'(busy), 32'd1);
    wlog.delete(); done_seen = 0;
    send(8'hAA); send(8'h55);
    send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
    chk_log("resync", 8'hA1, 8'hA2, 8'hA3, 8'hA4);
    chk("resync_done", 32'(done_seen), 32'd1);
    $display("scenario timeout: errs=%0d cnt=%0d", err_seen, frame_cnt);

    // byte/timeout collision: 7 ticks, then a byte together with the 8th
    err_seen = 0; wlog.delete();
    do_arm(); send(8'hAA); send(8'h55); send(8'hC0);
    for (int i = 0; i < TO - 1; i++) tick();
    cyc(0, 0, 0, 1, 1, 8'hC1);
    chk("collision_we", 32'(we), 32'd1);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("collision_no_err", 32'(err_seen), 32'd0);
    tick();
    chk("collision_err_after_restart", 32'(err_seen), 32'd1);
    $display("scenario collision: writes=%0d errs=%0d", wlog.size(), err_seen);

    // abort together with a payload byte
    cyc(0, 0, 1, 0, 0, 8'h00);
    wlog.delete();
    do_arm(); send(8'hAA); send(8'h55); send(8'h01);
    cyc(0, 0, 1, 0, 1, 8'h02);
    chk("abort_nwrites", 32'(wlog.size()), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    // arm + abort together stays idle
    cyc(0, 1, 1, 0, 0, 8'h00);
    chk("arm_abort_busy", 32'(busy), 32'd0);

    // reset mid-LOAD
    do_arm(); send(8'hAA); send(8'h55); send(8'h77);
    cyc(1, 0, 0, 0, 1, 8'h78);
    chk("reset_outputs", 32'({busy, we, frame_done, frame_err, frame_cnt, waddr, wdata}), 32'd0);
    $display("scenario abort/reset: busy=%0d cnt=%0d", busy, frame_cnt);

    // counter wrap: 256 frames
    done_seen = 0;
    for (int f = 0; f < 256; f++) begin
      do_arm(); send(8'hAA); send(8'h55);
      for (int i = 0; i < PIX; i++) send(8'(f + i));
    end
    chk("wrap_done_count", 32'(done_seen), 32'd256);
    chk("wrap_cnt", 32'(frame_cnt), 32'd0);
    $display("scenario wrap: frames=%0d cnt=%0d", done_seen, frame_cnt);

    // randomized traffic
    for (int seg = 0; seg < 20; seg++) begin
      vprob = (seg % 2 == 0) ? 50 : 8;
      tprob = (seg % 2 == 0) ? 25 : 60;
      for (int i = 0; i < 200; i++) begin
        sel = int'($urandom_range(0, 3));
        b = (sel == 0) ? 8'hAA : (sel == 1) ? 8'h55 : 8'($urandom);
        cyc($urandom_range(0, 999) == 0, $urandom_range(0, 99) < 4,
            $urandom_range(0, 299) == 0, $urandom_range(0, 99) < tprob,
            $urandom_range(0, 99) < vprob, b);
      end
    end
    $display("scenario random: frames=%0d errs=%0d", done_seen, err_seen);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_ctrl.md
# uart_frame_ctrl

Sequencer that turns the byte stream from the UART receiver into complete image frames in the frame-buffer BRAM. It sits between the UART receiver's `rx_done_tick`/`dout` outputs and the BRAM write port. It hunts for a two-byte sync header, then writes exactly `PIX_MAX` payload bytes to consecutive addresses. It also aborts and resynchronises when the byte stream stalls mid-frame.

## Interface
- `PIX_MAX`, 76800, payload bytes per frame (320*240)
- `ADDR_W`, 17, BRAM address width; must satisfy 2^ADDR_W >= PIX_MAX
- `SYNC0`, 8'hAA, first header byte
- `SYNC1`, 8'h55, second header byte
- `TIMEOUT_TICKS`, 4096, maximum `s_tick` pulses allowed between payload bytes
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `s_tick`  in  1  16x-baud sample tick, shared with the UART receiver
- `rx_done_tick`  in  1  one-cycle strobe: `rx_data` holds a new byte
- `rx_data`  in  8  received byte
- `arm`  in  1  one-cycle request to capture one frame
- `abort`  in  1  one-cycle request to cancel capture
- `busy`  out  1  high whenever state != IDLE
- `we`  out  1  BRAM write enable, one-cycle pulse
- `waddr`  out  ADDR_W  BRAM write address
- `wdata`  out  8  BRAM write data
- `frame_done`  out  1  one-cycle pulse: frame fully written
- `frame_err`  out  1  one-cycle pulse: frame aborted by timeout
- `frame_cnt`  out  8  number of completed frames, wraps 255->0

## Operation
- State machine with four states: IDLE, HUNT0, HUNT1, LOAD.
- **IDLE**
  - `arm` -> HUNT0.
  - Bytes arriving in IDLE are ignored.
- **HUNT0**
  - Byte == SYNC0 -> HUNT1.
  - Any other byte -> stay in HUNT0.
- **HUNT1**
  - Byte == SYNC1 -> LOAD, pixel counter cleared to 0, gap counter cleared.
  - Byte == SYNC0 -> stay in HUNT1.
  - Any other byte -> HUNT0.
- **LOAD**
  - Each byte is written at address = pixel counter, then the counter increments.
  - Each byte clears the gap counter.
  - The byte written at counter == PIX_MAX-1 completes the frame: `frame_done` pulses, `frame_cnt` increments, next state is IDLE.
  - The pixel counter never exceeds PIX_MAX-1; there is no address wrap within a frame.
- **Timeout (LOAD only)**
  - The gap counter increments on every `s_tick`.
  - When the gap counter reaches TIMEOUT_TICKS: `frame_err` pulses, next state is HUNT0 (stays armed and resyncs), `frame_cnt` is unchanged.
  - Bytes already written to BRAM are not cleared.
- **Priority within one cycle:** `abort` > byte > timeout.
  - `abort` in any state -> IDLE; no `we`, `frame_done` or `frame_err` is produced from that cycle's byte.
  - If a byte arrives in the same cycle the gap counter would reach its limit, the byte is accepted, the gap counter clears, and there is no error.
- `arm` while `busy` is ignored.
- `arm` and `abort` in the same cycle in IDLE -> stay in IDLE.
- Gap counter width is clog2(TIMEOUT_TICKS+1); it saturates and never wraps.

## Timing
- All outputs are registered.
- **Reset values:** state IDLE; `busy`, `we`, `frame_done`, `frame_err` = 0; `waddr` = 0; `wdata` = 0; `frame_cnt` = 0; pixel and gap counters = 0.
- **Reset mid-frame:** takes effect on the next edge; no terminating pulses are emitted.
- **Latency:**
  - `rx_done_tick` in cycle N (LOAD) -> `we`=1 with `waddr`/`wdata` valid in cycle N+1.
  - `we` is low in every other cycle.
  - `waddr`/`wdata` hold their last values while `we`=0.
- `frame_done` is asserted in the same cycle as the final `we` (N+1). `busy` falls in cycle N+1.
- `frame_err` is asserted one cycle after the `s_tick` that reaches the limit. `busy` stays high.
- `arm` in cycle N -> `busy`=1 in cycle N+1. A header byte can be accepted from cycle N+1 onward.
- Back-to-back `rx_done_tick` in consecutive cycles must be supported: one `we` per strobe, with no drops.

## Test plan
All scenarios use PIX_MAX=4 and TIMEOUT_TICKS=8 unless noted.
- **Nominal frame:** reset, arm, send AA 55 10 20 30 40.
  - Required: four `we` pulses, addr 0..3 with data 10/20/30/40.
  - Required: `frame_done` with the 4th `we`; `frame_cnt`=1; `busy`=0 afterwards.
- **Header hunting:** arm, send 00 AA AA 55 01 02 03 04.
  - Required: payload written to addr 0..3 = 01..04.
  - Then send 12 AA 13 AA 55 + 4 bytes without re-arming: no `we` at all (block is in IDLE).
- **Timeout resync:** arm, AA 55 01 02, then 8 `s_tick` with no byte.
  - Required: `frame_err` pulse, `frame_cnt` unchanged, `busy` stays 1.
  - Then AA 55 + 4 bytes: writes restart at addr 0, followed by `frame_done`.
- **Byte/timeout collision:** in LOAD, deliver a byte in the same cycle as the 8th `s_tick`.
  - Required: `we` issued, no `frame_err`, gap counter restarts.
- **Abort and reset:**
  - Arm, AA 55 01, then `abort` together with the next `rx_done_tick`: no `we` for that byte, IDLE next cycle.
  - Assert `reset` mid-LOAD: all outputs return to their reset values one cycle later.
- **Counter wrap:** force 256 complete frames (PIX_MAX=1).
  - Required: `frame_cnt` reads 0 after the 256th `frame_done`.
